// File: rtl/ethernet_mdio_responder.sv
// ethernet_mdio_responder: Clause 22 MDIO target (PHY-side management slave).
// Oversamples MDC/MDIO on clk. It decodes read/write frames addressed to phy_addr, drives a
// 32 x 16-bit register strobe interface, and serves read data back onto the MDIO pad.
// Ports: clk/rst_n (async active-low); phy_addr strap; mdc, mdio_rx_data from the pad;
//   mdio_tx_data/mdio_tx_en to the pad buffer; reg_addr/reg_rd/reg_rd_data/reg_wr/reg_wr_data
//   register-file strobes (read data is expected 1 clk after reg_rd); frame_err one-clk pulse.
// Optional build macro MDIO_BROADCAST_EN: PHYAD 0 additionally matches WRITE frames.
module ethernet_mdio_responder #(
   parameter int PREAMBLE_LEN = 32,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  phy_addr,
   input  logic        mdc,
   input  logic        mdio_rx_data,
   output logic        mdio_tx_data,
   output logic        mdio_tx_en,
   output logic [4:0]  reg_addr,
   output logic        reg_rd,
   input  logic [15:0] reg_rd_data,
   output logic        reg_wr,
   output logic [15:0] reg_wr_data,
   output logic        frame_err
);

   localparam int PW = (PREAMBLE_LEN < 1) ? 1 : $clog2(PREAMBLE_LEN + 1);
   localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);

`ifdef MDIO_BROADCAST_EN
   localparam logic BCAST_EN = 1'b1;
`else
   localparam logic BCAST_EN = 1'b0;
`endif

   // OP, PHYAD and REGAD are collected by one 12-bit header state.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ST    = 3'd1;
   localparam logic [2:0] S_HDR   = 3'd2;
   localparam logic [2:0] S_TA    = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d, mdio_sync_q, mdio_sync_d;
   logic                   mdc_prev_q, mdc_prev_d;
   logic [2:0]             state_q, state_d;
   logic [PW-1:0]          pre_cnt_q, pre_cnt_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [11:0]            hdr_q, hdr_d;
   logic [15:0]            data_sr_q, data_sr_d;
   logic [15:0]            rd_data_q, rd_data_d;
   logic                   rd_pend_q, rd_pend_d;
   logic                   reg_rd_q, reg_rd_d, reg_wr_q, reg_wr_d, frame_err_q, frame_err_d;
   logic [4:0]             reg_addr_q, reg_addr_d;
   logic [15:0]            reg_wr_data_q, reg_wr_data_d;
   logic                   tx_en_q, tx_en_d, tx_data_q, tx_data_d;

   logic        mdc_s, mdio_s, rise, fall, pa_match, wr_match, is_rd;
   logic [11:0] hdr_full;

   assign mdc_s    = mdc_sync_q[SYNC_STAGES-1];
   assign mdio_s   = mdio_sync_q[SYNC_STAGES-1];
   assign rise     = mdc_s & ~mdc_prev_q;
   assign fall     = ~mdc_s & mdc_prev_q;
   // Header including the bit arriving on this rise: {op[1:0], phyad[4:0], regad[4:0]}.
   assign hdr_full = {hdr_q[10:0], mdio_s};
   assign pa_match = (hdr_full[9:5] == phy_addr);
   assign wr_match = pa_match | (BCAST_EN & (hdr_full[9:5] == 5'd0));
   assign is_rd    = (hdr_q[11:10] == 2'b10);

   always_comb begin
      mdc_sync_d    = {mdc_sync_q[SYNC_STAGES-2:0], mdc};
      mdio_sync_d   = {mdio_sync_q[SYNC_STAGES-2:0], mdio_rx_data};
      mdc_prev_d    = mdc_s;
      state_d       = state_q;
      pre_cnt_d     = pre_cnt_q;
      cnt_d         = cnt_q;
      hdr_d         = hdr_q;
      data_sr_d     = data_sr_q;
      rd_data_d     = rd_data_q;
      rd_pend_d     = reg_rd_q;
      reg_rd_d      = 1'b0;
      reg_wr_d      = 1'b0;
      frame_err_d   = 1'b0;
      reg_addr_d    = reg_addr_q;
      reg_wr_data_d = reg_wr_data_q;
      tx_en_d       = tx_en_q;
      tx_data_d     = tx_data_q;

      // Register file returns data one clk after the strobe.
      if (rd_pend_q) rd_data_d = reg_rd_data;

      if (rise) begin
         case (state_q)
            S_IDLE: begin
               if (mdio_s) begin
                  if (pre_cnt_q < PRE_MAX) pre_cnt_d = pre_cnt_q + PW'(1);
               end else begin
                  // This zero is ST bit 0 when the preamble is complete.
                  if (pre_cnt_q == PRE_MAX) state_d = S_ST;
                  pre_cnt_d = '0;
               end
            end
            S_ST: begin
               cnt_d = 5'd0;
               state_d = mdio_s ? S_HDR : S_IDLE;
            end
            S_HDR: begin
               hdr_d = hdr_full;
               if (cnt_q == 5'd11) begin
                  // Drain the 2 TA + 16 data rises that remain in the frame.
                  cnt_d   = 5'd17;
                  state_d = S_DRAIN;
                  case (hdr_full[11:10])
                     2'b10: if (pa_match) begin
                        state_d    = S_TA;
                        cnt_d      = 5'd0;
                        reg_rd_d   = 1'b1;
                        reg_addr_d = hdr_full[4:0];
                     end
                     2'b01: if (wr_match) begin
                        state_d = S_TA;
                        cnt_d   = 5'd0;
                     end
                     default: frame_err_d = pa_match;
                  endcase
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            S_TA: begin
               data_sr_d = {data_sr_q[14:0], mdio_s};
               if (cnt_q == 5'd0) begin
                  cnt_d = 5'd1;
               end else if (!is_rd && ({data_sr_q[0], mdio_s} != 2'b10)) begin
                  frame_err_d = 1'b1;
                  cnt_d       = 5'd15;
                  state_d     = S_DRAIN;
               end else begin
                  cnt_d   = 5'd0;
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               data_sr_d = {data_sr_q[14:0], mdio_s};
               if (cnt_q == 5'd15) begin
                  state_d   = S_IDLE;
                  pre_cnt_d = '0;
                  if (!is_rd) begin
                     reg_wr_d      = 1'b1;
                     reg_addr_d    = hdr_q[4:0];
                     reg_wr_data_d = {data_sr_q[14:0], mdio_s};
                  end
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            S_DRAIN: begin
               if (cnt_q == 5'd0) begin
                  state_d   = S_IDLE;
                  pre_cnt_d = '0;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            default: begin
               state_d   = S_IDLE;
               pre_cnt_d = '0;
            end
         endcase
      end

      // Pad changes only on MDC fall: TA1 drives 0, then D15..D0, released once the frame ends.
      if (fall) begin
         tx_en_d   = is_rd && ((state_q == S_TA && cnt_q == 5'd1) || state_q == S_DATA);
         tx_data_d = is_rd && (state_q == S_DATA) && rd_data_q[4'd15 - cnt_q[3:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdc_sync_q    <= '0;
         mdio_sync_q   <= '0;
         mdc_prev_q    <= 1'b0;
         state_q       <= S_IDLE;
         pre_cnt_q     <= '0;
         cnt_q         <= 5'd0;
         hdr_q         <= 12'd0;
         data_sr_q     <= 16'd0;
         rd_data_q     <= 16'd0;
         rd_pend_q     <= 1'b0;
         reg_rd_q      <= 1'b0;
         reg_wr_q      <= 1'b0;
         frame_err_q   <= 1'b0;
         reg_addr_q    <= 5'd0;
         reg_wr_data_q <= 16'd0;
         tx_en_q       <= 1'b0;
         tx_data_q     <= 1'b0;
      end else begin
         mdc_sync_q    <= mdc_sync_d;
         mdio_sync_q   <= mdio_sync_d;
         mdc_prev_q    <= mdc_prev_d;
         state_q       <= state_d;
         pre_cnt_q     <= pre_cnt_d;
         cnt_q         <= cnt_d;
         hdr_q         <= hdr_d;
         data_sr_q     <= data_sr_d;
         rd_data_q     <= rd_data_d;
         rd_pend_q     <= rd_pend_d;
         reg_rd_q      <= reg_rd_d;
         reg_wr_q      <= reg_wr_d;
         frame_err_q   <= frame_err_d;
         reg_addr_q    <= reg_addr_d;
         reg_wr_data_q <= reg_wr_data_d;
         tx_en_q       <= tx_en_d;
         tx_data_q     <= tx_data_d;
      end
   end

   assign mdio_tx_en   = tx_en_q;
   assign mdio_tx_data = tx_data_q;
   assign reg_addr     = reg_addr_q;
   assign reg_rd       = reg_rd_q;
   assign reg_wr       = reg_wr_q;
   assign reg_wr_data  = reg_wr_data_q;
   assign frame_err    = frame_err_q;

endmodule
